// File: rtl/cache_model.sv
// Two-level write-through cache model: a 2-line L1 and an 8-line L2, both
// direct-mapped with 2-word lines, in front of a 256x32 backing memory.
// Every non-reset cycle is one access; lookup is combinational and all
// state (fills, writes, counters) changes on the following rising edge.

// One direct-mapped cache level; the line count is 2**INDEX_W and the tag is
// whatever is left of the 8-bit word address above index and offset.
module cache_level #(
    parameter int INDEX_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  address,
    input  logic        write_en,
    input  logic [31:0] write_data,
    input  logic        fill_en,
    input  logic [63:0] fill_line,
    output logic        hit,
    output logic [63:0] rd_line
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 7 - INDEX_W;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        cachemem_q [LINES][2];
    logic [31:0]        cachemem_d [LINES][2];
    logic [TAG_W-1:0]   tags_q [LINES];
    logic [TAG_W-1:0]   tags_d [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   valid_d;

    assign index   = address[INDEX_W:1];
    assign tag     = address[7:INDEX_W+1];
    assign hit     = valid_q[index] && (tags_q[index] == tag);
    assign rd_line = {cachemem_q[index][1], cachemem_q[index][0]};

    // Next state: a fill replaces the whole line unconditionally; a write
    // only touches the addressed word when the line is already resident.
    always_comb begin
        cachemem_d = cachemem_q;
        tags_d     = tags_q;
        valid_d    = valid_q;
        if (fill_en) begin
            cachemem_d[index][0] = fill_line[31:0];
            cachemem_d[index][1] = fill_line[63:32];
            tags_d[index]        = tag;
            valid_d[index]       = 1'b1;
        end else if (write_en && hit) begin
            cachemem_d[index][address[0]] = write_data;
        end
    end

    // Storage registers; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        cachemem_q <= cachemem_d;
        tags_q     <= tags_d;
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end
endmodule

module cache_model (
    input  logic        clk,
    input  logic        rst,
    input  logic        report,
    input  logic        write_en,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);
    logic [31:0] mem_words [256];
    logic [63:0] mem_line;
    logic        mem_we;
    logic        l1_hit;
    logic        l2_hit;
    logic [63:0] l1_line;
    logic [63:0] l2_line;
    logic        l1_wr_en;
    logic        l2_wr_en;
    logic        l1_fill;
    logic        l2_fill;
    logic [63:0] l1_fill_line;
    logic [31:0] l1_hits_q, l1_hits_d;
    logic [31:0] l1_misses_q, l1_misses_d;
    logic [31:0] l2_hits_q, l2_hits_d;
    logic [31:0] l2_misses_q, l2_misses_d;

    // Backing memory: each word resets to its own address so the initial
    // contents are self-identifying.
    for (genvar gi = 0; gi < 256; gi++) begin : g_mem
        logic [31:0] word_q;
        logic [31:0] word_d;

        // Word update: written whenever a write access targets this address.
        always_comb begin
            word_d = word_q;
            if (mem_we && (address == 8'(gi))) begin
                word_d = write_data;
            end
        end

        // Word register with its reset pattern.
        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= 32'(gi);
            end else begin
                word_q <= word_d;
            end
        end

        assign mem_words[gi] = word_q;
    end

    assign mem_line = {mem_words[{address[7:1], 1'b1}], mem_words[{address[7:1], 1'b0}]};

    cache_level #(.INDEX_W(1)) l1dcache (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_en   (l1_wr_en),
        .write_data (write_data),
        .fill_en    (l1_fill),
        .fill_line  (l1_fill_line),
        .hit        (l1_hit),
        .rd_line    (l1_line)
    );

    cache_level #(.INDEX_W(3)) l2cache (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_en   (l2_wr_en),
        .write_data (write_data),
        .fill_en    (l2_fill),
        .fill_line  (mem_line),
        .hit        (l2_hit),
        .rd_line    (l2_line)
    );

    // Access control: data return, fill/write strobes and counter updates.
    // Writes always reach memory and count at both levels; reads only
    // consult (and count) L2 after an L1 miss.
    always_comb begin
        read_data    = 32'd0;
        mem_we       = 1'b0;
        l1_wr_en     = 1'b0;
        l2_wr_en     = 1'b0;
        l1_fill      = 1'b0;
        l2_fill      = 1'b0;
        l1_fill_line = mem_line;
        l1_hits_d    = l1_hits_q;
        l1_misses_d  = l1_misses_q;
        l2_hits_d    = l2_hits_q;
        l2_misses_d  = l2_misses_q;
        if (!rst) begin
            if (write_en) begin
                read_data = write_data;
                mem_we    = 1'b1;
                l1_wr_en  = 1'b1;
                l2_wr_en  = 1'b1;
                if (l1_hit) l1_hits_d = l1_hits_q + 32'd1;
                else        l1_misses_d = l1_misses_q + 32'd1;
                if (l2_hit) l2_hits_d = l2_hits_q + 32'd1;
                else        l2_misses_d = l2_misses_q + 32'd1;
            end else if (l1_hit) begin
                read_data = address[0] ? l1_line[63:32] : l1_line[31:0];
                l1_hits_d = l1_hits_q + 32'd1;
            end else begin
                l1_misses_d = l1_misses_q + 32'd1;
                if (l2_hit) begin
                    read_data    = address[0] ? l2_line[63:32] : l2_line[31:0];
                    l1_fill      = 1'b1;
                    l1_fill_line = l2_line;
                    l2_hits_d    = l2_hits_q + 32'd1;
                end else begin
                    read_data   = mem_words[address];
                    l1_fill     = 1'b1;
                    l2_fill     = 1'b1;
                    l2_misses_d = l2_misses_q + 32'd1;
                end
            end
        end
    end

    // Hit/miss counters, wrapping at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            l1_hits_q   <= 32'd0;
            l1_misses_q <= 32'd0;
            l2_hits_q   <= 32'd0;
            l2_misses_q <= 32'd0;
        end else begin
            l1_hits_q   <= l1_hits_d;
            l1_misses_q <= l1_misses_d;
            l2_hits_q   <= l2_hits_d;
            l2_misses_q <= l2_misses_d;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only counter dump, showing the totals before this edge.
    always_ff @(posedge clk) begin
        if (report) begin
            $display("cache_model report: l1_hits=%0d l1_misses=%0d l2_hits=%0d l2_misses=%0d",
                     l1_hits_q, l1_misses_q, l2_hits_q, l2_misses_q);
        end
    end
`endif
endmodule

// File: tb/tb_cache_model.sv
// Bench for cache_model. The reference model exploits the fact that every
// level is write-through: any access returns the memory word (or the write
// data), so it only tracks memory contents plus which line address each
// cache slot currently holds, and derives hits from that.
module tb_cache_model;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        report = 1'b0;
    logic        write_en = 1'b0;
    logic [7:0]  address = 8'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem [256];
    int          m_l1 [2];
    int          m_l2 [8];
    logic [31:0] m_l1h, m_l1m, m_l2h, m_l2m;

    cache_model dut (
        .clk        (clk),
        .rst        (rst),
        .report     (report),
        .write_en   (write_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 32'(i);
        for (int i = 0; i < 2; i++) m_l1[i] = -1;
        for (int i = 0; i < 8; i++) m_l2[i] = -1;
        m_l1h = 0; m_l1m = 0; m_l2h = 0; m_l2m = 0;
    endtask

    task automatic check_counters(input string name);
        n_vec++;
        if ({dut.l1_hits_q, dut.l1_misses_q, dut.l2_hits_q, dut.l2_misses_q} !== {m_l1h, m_l1m, m_l2h, m_l2m}) begin
            n_err++;
            $display("FAIL %s counters got l1h=%0d l1m=%0d l2h=%0d l2m=%0d want l1h=%0d l1m=%0d l2h=%0d l2m=%0d",
                     name, dut.l1_hits_q, dut.l1_misses_q, dut.l2_hits_q, dut.l2_misses_q,
                     m_l1h, m_l1m, m_l2h, m_l2m);
        end
    endtask

    // One access cycle: drive at the falling edge, check the combinational
    // result, advance the model, then check counters after the rising edge.
    task automatic access(input bit we, input logic [7:0] a, input logic [31:0] wd, input bit rep);
        int line, i1, i2;
        bit e1, e2;
        logic [31:0] exp;
        @(negedge clk);
        rst = 1'b0; write_en = we; address = a; write_data = wd; report = rep;
        line = int'(a) / 2;
        i1 = line % 2;
        i2 = line % 8;
        e1 = (m_l1[i1] == line);
        e2 = (m_l2[i2] == line);
        exp = we ? wd : m_mem[a];
        #1;
        n_vec++;
        if (read_data !== exp) begin
            n_err++;
            $display("FAIL read_data %s @%02h got %08h want %08h", we ? "wr" : "rd", a, read_data, exp);
        end
        n_vec++;
        if (dut.l1_hit !== e1) begin
            n_err++;
            $display("FAIL l1_hit @%02h got %0b want %0b", a, dut.l1_hit, e1);
        end
        if (we || !e1) begin
            n_vec++;
            if (dut.l2_hit !== e2) begin
                n_err++;
                $display("FAIL l2_hit @%02h got %0b want %0b", a, dut.l2_hit, e2);
            end
        end
        if (we) begin
            m_mem[a] = wd;
            if (e1) m_l1h++; else m_l1m++;
            if (e2) m_l2h++; else m_l2m++;
        end else if (e1) begin
            m_l1h++;
        end else begin
            m_l1m++;
            if (e2) m_l2h++; else m_l2m++;
            m_l1[i1] = line;
            m_l2[i2] = line;
        end
        $display("access %s addr=%02h wdata=%08h read_data=%08h", we ? "wr" : "rd", a, wd, read_data);
        @(posedge clk);
        #1;
        report = 1'b0;
        check_counters("access");
    endtask

    // Hold reset for a few cycles with random (ignored) access inputs.
    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            rst = 1'b1;
            write_en = 1'($urandom);
            address = 8'($urandom);
            write_data = $urandom;
            #1;
            n_vec++;
            if (read_data !== 32'd0) begin
                n_err++;
                $display("FAIL reset_read_data got %08h want 00000000", read_data);
            end
        end
        @(posedge clk);
        #1;
        model_reset();
        check_counters("reset");
        n_vec++;
        if ({dut.l1dcache.valid_q, dut.l2cache.valid_q} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_valid got %03h want 000", {dut.l1dcache.valid_q, dut.l2cache.valid_q});
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        for (int i = 0; i < 6; i++) access(1'b0, 8'($urandom), 32'd0, 1'b0);
    endtask

    // Directed walk through cold read, conflict, L2 hit and the write cases.
    task automatic test_directed();
        do_reset(2);
        access(1'b0, 8'h20, 32'd0, 1'b0);
        access(1'b0, 8'h20, 32'd0, 1'b0);
        access(1'b0, 8'h28, 32'd0, 1'b0);
        n_vec++;
        if ({dut.l1dcache.valid_q[0], dut.l1dcache.tags_q[0]} !== {1'b1, 6'h0A} ||
            {dut.l2cache.valid_q[4], dut.l2cache.tags_q[4]} !== {1'b1, 4'h2} ||
            {dut.l2cache.valid_q[0], dut.l2cache.tags_q[0]} !== {1'b1, 4'h2}) begin
            n_err++;
            $display("FAIL conflict_tags got l1[0]=%02h l2[4]=%01h l2[0]=%01h want l1[0]=0a l2[4]=2 l2[0]=2",
                     dut.l1dcache.tags_q[0], dut.l2cache.tags_q[4], dut.l2cache.tags_q[0]);
        end
        access(1'b0, 8'h20, 32'd0, 1'b0);
        access(1'b0, 8'h20, 32'd0, 1'b0);
        access(1'b1, 8'h20, 32'h00ABCDEF, 1'b0);
        access(1'b0, 8'h20, 32'd0, 1'b0);
        access(1'b1, 8'h28, 32'h00012345, 1'b0);
        n_vec++;
        if (dut.l1dcache.tags_q[0] !== 6'h08) begin
            n_err++;
            $display("FAIL write_no_allocate l1 tag got %02h want 08", dut.l1dcache.tags_q[0]);
        end
        access(1'b0, 8'h28, 32'd0, 1'b0);
    endtask

    // Totals after the directed walk, then a report pulse and a fresh reset.
    task automatic test_report();
        n_vec++;
        if ({dut.l1_hits_q, dut.l1_misses_q, dut.l2_hits_q, dut.l2_misses_q} !== {32'd4, 32'd5, 32'd4, 32'd2}) begin
            n_err++;
            $display("FAIL report_totals got %0d/%0d/%0d/%0d want 4/5/4/2",
                     dut.l1_hits_q, dut.l1_misses_q, dut.l2_hits_q, dut.l2_misses_q);
        end
        access(1'b0, 8'h28, 32'd0, 1'b1);
        do_reset(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 31));
            access(1'b1, a, $urandom, 1'b0);
            access(1'b0, a, 32'd0, 1'b0);
            access(1'b0, a ^ 8'h01, 32'd0, 1'b0);
            access(1'b1, a, $urandom, 1'b0);
            access(1'b0, a, 32'd0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 47));
            access(1'($urandom_range(0, 3) == 0), a, $urandom, 1'($urandom_range(0, 63) == 0));
        end
    endtask

    // Writes followed by a reset: memory must return to its initial pattern.
    task automatic test_mid_reset();
        logic [7:0] addrs [4];
        for (int i = 0; i < 4; i++) begin
            addrs[i] = 8'($urandom);
            access(1'b1, addrs[i], $urandom | 32'h8000_0000, 1'b0);
            access(1'b0, addrs[i], 32'd0, 1'b0);
        end
        do_reset(1);
        for (int i = 0; i < 4; i++) access(1'b0, addrs[i], 32'd0, 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_report();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
